amstrad_mem_sched: RTL and testbench

AMSTRAD_MEM_SCHED -- requirements
Module: amstrad_mem_sched

---
 rtl/amstrad_mem_sched.sv | 154 +++++++++++++++
 tb/tb_amstrad_mem_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amstrad_mem_sched.sv
// Amstrad CPC memory slot scheduler: 1 MHz video/CPU interleave on a 4 MHz enable, with Z80 WAIT alignment.
// Optional macro AMSTRAD_IO_WAIT_EN makes cpu_iorq cycles go through the same wait/slot alignment.
module amstrad_mem_sched (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE_4,
  input  logic        cpu_mreq,
  input  logic        cpu_iorq,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [13:0] crtc_ma,
  input  logic [4:0]  crtc_ra,
  output logic [1:0]  phase,
  output logic        cyc1MHz,
  output logic        cpu_wait_n,
  output logic        mem_sel,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        cpu_rd_stb,
  output logic        vid_stb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } cpu_state_t;

  cpu_state_t  state_r, state_nxt_s;
  logic [1:0]  phase_nxt_s;
  logic        req_s, io_s, start_s, in_acc_s, strobe_s;
  logic [15:0] acc_addr_r, acc_addr_nxt_s;
  logic        acc_wr_r, acc_wr_nxt_s;
  logic        acc_io_r, acc_io_nxt_s;
  logic [14:0] vid_word_r, vid_word_nxt_s;
  logic        mem_sel_nxt_s, mem_we_nxt_s, cpu_rd_stb_nxt_s;
  logic [15:0] mem_addr_nxt_s;
  logic        unused_bits_s;

`ifdef AMSTRAD_IO_WAIT_EN
  // A simultaneous mreq+iorq is a memory cycle; only a pure iorq is an I/O cycle.
  assign req_s         = cpu_mreq | cpu_iorq;
  assign io_s          = ~cpu_mreq & cpu_iorq;
  assign unused_bits_s = ^{crtc_ma[11:10], crtc_ra[4:3]};
`else
  assign req_s         = cpu_mreq;
  assign io_s          = 1'b0;
  assign unused_bits_s = ^{crtc_ma[11:10], crtc_ra[4:3], cpu_iorq};
`endif

  // Next-state and next-output decode; everything is evaluated for the phase about to be entered.
  always_comb begin
    phase_nxt_s = phase + 2'd1;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_nxt_s = (phase_nxt_s == 2'd2) ? ACCESS : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else if (phase_nxt_s == 2'd2) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      ACCESS: begin
        if (phase_nxt_s == 2'd0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      DONE: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

    start_s = (state_nxt_s == ACCESS) && (state_r != ACCESS);
    if (start_s) begin
      acc_addr_nxt_s = cpu_addr;
      acc_wr_nxt_s   = cpu_wr;
      acc_io_nxt_s   = io_s;
    end else begin
      acc_addr_nxt_s = acc_addr_r;
      acc_wr_nxt_s   = acc_wr_r;
      acc_io_nxt_s   = acc_io_r;
    end

    if (phase_nxt_s == 2'd0) begin
      vid_word_nxt_s = {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0]};
    end else begin
      vid_word_nxt_s = vid_word_r;
    end

    // I/O cycles take the CPU slot for timing only; memory stays with the video side.
    in_acc_s      = (state_nxt_s == ACCESS);
    mem_sel_nxt_s = in_acc_s & ~acc_io_nxt_s;
    if (mem_sel_nxt_s) begin
      mem_addr_nxt_s = acc_addr_nxt_s;
    end else begin
      mem_addr_nxt_s = {vid_word_nxt_s, 1'b0};
    end

    strobe_s         = in_acc_s && (phase_nxt_s == 2'd3) && !acc_io_nxt_s;
    mem_we_nxt_s     = strobe_s & acc_wr_nxt_s;
    cpu_rd_stb_nxt_s = strobe_s & ~acc_wr_nxt_s;
  end

  // State and registered outputs; reset is synchronous and ignores CE_4.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase      <= 2'd0;
      state_r    <= IDLE;
      cyc1MHz    <= 1'b1;
      cpu_wait_n <= 1'b1;
      mem_sel    <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_we     <= 1'b0;
      cpu_rd_stb <= 1'b0;
      vid_stb    <= 1'b0;
      acc_addr_r <= 16'h0000;
      acc_wr_r   <= 1'b0;
      acc_io_r   <= 1'b0;
      vid_word_r <= 15'h0000;
    end else if (CE_4) begin
      phase      <= phase_nxt_s;
      state_r    <= state_nxt_s;
      cyc1MHz    <= (phase_nxt_s == 2'd0);
      cpu_wait_n <= (state_nxt_s != WAIT);
      mem_sel    <= mem_sel_nxt_s;
      mem_addr   <= mem_addr_nxt_s;
      mem_we     <= mem_we_nxt_s;
      cpu_rd_stb <= cpu_rd_stb_nxt_s;
      vid_stb    <= (phase_nxt_s == 2'd1);
      acc_addr_r <= acc_addr_nxt_s;
      acc_wr_r   <= acc_wr_nxt_s;
      acc_io_r   <= acc_io_nxt_s;
      vid_word_r <= vid_word_nxt_s;
    end
  end

endmodule

// File: tb/tb_amstrad_mem_sched.sv
// Self-checking bench for amstrad_mem_sched: directed vectors, a tick-level slot model and per-cycle compare.
module tb_amstrad_mem_sched;

  logic        CLK = 1'b0;
  logic        RESET, CE_4, cpu_mreq, cpu_iorq, cpu_wr;
  logic [15:0] cpu_addr;
  logic [13:0] crtc_ma;
  logic [4:0]  crtc_ra;
  logic [1:0]  phase;
  logic        cyc1MHz, cpu_wait_n, mem_sel, mem_we, cpu_rd_stb, vid_stb;
  logic [15:0] mem_addr;

  always #5 CLK = ~CLK;

  amstrad_mem_sched dut (
    .CLK(CLK), .RESET(RESET), .CE_4(CE_4),
    .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .crtc_ma(crtc_ma), .crtc_ra(crtc_ra),
    .phase(phase), .cyc1MHz(cyc1MHz), .cpu_wait_n(cpu_wait_n), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_we(mem_we), .cpu_rd_stb(cpu_rd_stb), .vid_stb(vid_stb)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase counter, remaining wait ticks, remaining access ticks, done-hold flag.
  bit m_valid = 1'b0;
  int m_ph, m_wl, m_acc_left, m_vma, m_vra;
  bit m_done, m_wr, m_io;
  int m_addr;
  bit e_wait_n, e_sel, e_we, e_rd;
  int e_addr;
  int gap_sel = 0;

  function automatic int vid_addr(input int ma, input int ra);
    return (((ma >> 12) & 3) << 14) | ((ra & 7) << 11) | ((ma & 1023) << 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b1; m_ph = 0; m_wl = 0; m_acc_left = 0; m_done = 1'b0;
    m_wr = 1'b0; m_io = 1'b0; m_addr = 0; m_vma = 0; m_vra = 0;
    e_wait_n = 1'b1; e_sel = 1'b0; e_we = 1'b0; e_rd = 1'b0; e_addr = 0;
  endtask

  task automatic model_start();
    m_acc_left = 2; m_addr = int'(cpu_addr); m_wr = cpu_wr;
`ifdef AMSTRAD_IO_WAIT_EN
    m_io = !cpu_mreq && cpu_iorq;
`else
    m_io = 1'b0;
`endif
  endtask

  task automatic model_tick();
    bit req;
`ifdef AMSTRAD_IO_WAIT_EN
    req = cpu_mreq || cpu_iorq;
`else
    req = cpu_mreq;
`endif
    m_ph = (m_ph + 1) % 4;
    if (m_ph == 0) begin m_vma = int'(crtc_ma); m_vra = int'(crtc_ra); end
    e_we = 1'b0; e_rd = 1'b0;
    if (m_acc_left > 0) begin
      m_acc_left--;
      if (m_acc_left == 1 && !m_io) begin e_we = m_wr; e_rd = !m_wr; end
      if (m_acc_left == 0) m_done = 1'b1;
    end else if (m_done) begin
      if (!req) m_done = 1'b0;
    end else if (m_wl > 0) begin
      if (!req) m_wl = 0;
      else begin m_wl--; if (m_wl == 0) model_start(); end
    end else if (req) begin
      m_wl = (2 - m_ph) & 3;   // ticks until the next CPU slot opens
      if (m_wl == 0) model_start();
    end
    e_wait_n = (m_wl == 0);
    e_sel    = (m_acc_left > 0) && !m_io;
    e_addr   = e_sel ? m_addr : vid_addr(m_vma, m_vra);
  endtask

  // One clock; model follows the DUT's view of RESET/CE_4 at this edge; inputs change 2 ns later.
  task automatic cycle();
    @(posedge CLK);
    if (RESET) model_reset();
    else if (CE_4 && m_valid) model_tick();
    #2;
  endtask

  task automatic tick();
    CE_4 = 1'b1;
    cycle();
    CE_4 = 1'b0;
    repeat (gap_sel % 3) cycle();
    gap_sel++;
  endtask

  task automatic advance_to(input int p);
    int n = 0;
    while (m_ph != p && n < 8) begin tick(); n++; end
    check("advance_to_bound", m_ph, p);
  endtask

  // Every cycle the outputs must match the model (holds between CE_4 ticks included).
  always @(negedge CLK) begin
    if (m_valid) begin
      check("phase",      int'(phase),      m_ph);
      check("cyc1MHz",    int'(cyc1MHz),    int'(m_ph == 0));
      check("vid_stb",    int'(vid_stb),    int'(m_ph == 1));
      check("cpu_wait_n", int'(cpu_wait_n), int'(e_wait_n));
      check("mem_sel",    int'(mem_sel),    int'(e_sel));
      check("mem_we",     int'(mem_we),     int'(e_we));
      check("cpu_rd_stb", int'(cpu_rd_stb), int'(e_rd));
      if (e_sel || m_ph < 2) check("mem_addr", int'(mem_addr), e_addr);
    end
  end

  initial begin
    int low, n;
    int stall_tab [4];
    stall_tab[0] = 2; stall_tab[1] = 1; stall_tab[2] = 0; stall_tab[3] = 3;

    RESET = 1'b1; CE_4 = 1'b0; cpu_mreq = 1'b0; cpu_iorq = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 16'h0000; crtc_ma = 14'h0000; crtc_ra = 5'd0;
    cycle(); cycle();
    RESET = 1'b0;
    check("rst_phase",  int'(phase),      0);
    check("rst_wait_n", int'(cpu_wait_n), 1);
    check("rst_sel",    int'(mem_sel),    0);
    check("rst_addr",   int'(mem_addr),   0);
    cycle();

    // Video address composition and hold through phase 1.
    crtc_ma = 14'h3005; crtc_ra = 5'd3;
    advance_to(3);
    tick();
    check("vid_addr_p0", int'(mem_addr), 32'hD80A);
    crtc_ma = 14'h0000; crtc_ra = 5'd0;
    tick();
    check("vid_addr_p1", int'(mem_addr), 32'hD80A);
    check("vid_stb_p1",  int'(vid_stb),  1);

    // Read seen at the phase-2 tick: no wait.
    cpu_addr = 16'h4000; cpu_wr = 1'b0; cpu_mreq = 1'b1;
    tick();
    check("rd_wait_n_p2", int'(cpu_wait_n), 1);
    check("rd_addr_p2",   int'(mem_addr),   32'h4000);
    tick();
    check("rd_stb_p3",    int'(cpu_rd_stb), 1);
    check("rd_addr_p3",   int'(mem_addr),   32'h4000);
    cpu_mreq = 1'b0;
    tick(); tick();

    // Write seen at phase 0: two wait ticks then write strobe at phase 3.
    advance_to(3);
    cpu_addr = 16'h1234; cpu_wr = 1'b1; cpu_mreq = 1'b1;
    low = 0;
    repeat (4) begin tick(); if (!cpu_wait_n) low++; end
    check("wr_wait_ticks", low, 2);
    check("wr_we_p3",      int'(mem_we),   1);
    check("wr_addr_p3",    int'(mem_addr), 32'h1234);
    cpu_mreq = 1'b0;
    tick(); tick();

    // Request dropped while waiting: abandoned, no strobe.
    advance_to(3);
    cpu_wr = 1'b0; cpu_mreq = 1'b1;
    tick();
    check("abort_wait_low", int'(cpu_wait_n), 0);
    cpu_mreq = 1'b0;
    tick();
    check("abort_wait_rel", int'(cpu_wait_n), 1);
    n = 0;
    repeat (4) begin tick(); if (cpu_rd_stb || mem_we) n++; end
    check("abort_no_strobe", n, 0);

    // I/O request at phase 3.
    advance_to(2);
    cpu_iorq = 1'b1;
    low = 0;
    repeat (4) begin tick(); if (!cpu_wait_n) low++; end
`ifdef AMSTRAD_IO_WAIT_EN
    check("io_wait_ticks", low, 3);
`else
    check("io_wait_ticks", low, 0);
`endif
    cpu_iorq = 1'b0;
    repeat (3) tick();

    // Held request (with iorq too, which counts as mreq) gives one access until released.
    advance_to(1);
    cpu_addr = 16'h8001; cpu_wr = 1'b0; cpu_mreq = 1'b1; cpu_iorq = 1'b1;
    n = 0;
    repeat (12) begin tick(); if (cpu_rd_stb) n++; end
    check("held_one_access", n, 1);
    cpu_mreq = 1'b0; cpu_iorq = 1'b0;
    tick();
    cpu_mreq = 1'b1;
    n = 0;
    repeat (8) begin tick(); if (cpu_rd_stb) n++; end
    check("reassert_access", n, 1);
    cpu_mreq = 1'b0;
    repeat (2) tick();

    // Stall length for each arrival phase.
    for (int p = 0; p < 4; p++) begin
      advance_to((p + 3) % 4);
      cpu_mreq = 1'b1;
      low = 0;
      repeat (4) begin tick(); if (!cpu_wait_n) low++; end
      check($sformatf("stall_from_p%0d", p), low, stall_tab[p]);
      cpu_mreq = 1'b0;
      repeat (3) tick();
    end

    // Reset during a write access: abandoned with no strobe.
    advance_to(1);
    cpu_addr = 16'hBEEF; cpu_wr = 1'b1; cpu_mreq = 1'b1;
    tick();
    check("rst_acc_sel", int'(mem_sel), 1);
    RESET = 1'b1; cpu_mreq = 1'b0;
    cycle();
    RESET = 1'b0;
    check("rst_acc_phase",  int'(phase),      0);
    check("rst_acc_we",     int'(mem_we),     0);
    check("rst_acc_wait_n", int'(cpu_wait_n), 1);
    n = 0;
    repeat (4) begin tick(); if (mem_we) n++; end
    check("rst_acc_no_we", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
